bk_stream_processor: RTL and testbench
======================================

// Module: bk_stream_processor
// PURPOSE
//  Parametrised successor of the bk processor datapath: one command-driven ALU/memory engine.
//  Commands arrive over a valid/ready handshake. Operands are selected from three data
//  inputs or from fed-back results. The 2*WIDTH result is stored to or loaded from an
//  internal MEM_DEPTH-entry memory. Sits between the host command interface and downstream consumers.
// PARAMETERS
//  WIDTH      8   operand width; results/memory words are 2*WIDTH
//  MEM_DEPTH  16  memory entries; localparam ADDR_W=$clog2(MEM_DEPTH), SH_W=$clog2(2*WIDTH)
// PORTS
//  clk        in   1        clock
//  rst        in   1        reset, synchronous and active-low
//  cmd_valid  in   1        command present
//  cmd_ready  out  1        engine can accept (high only in IDLE)
//  cmd_in     in   9        [8:6] opcode, [5:4] sel_a, [3:2] sel_b, [1:0] mode
//  din_1      in   WIDTH    operand source 0; also memory address (low ADDR_W bits)
//  din_2      in   WIDTH    operand source 1
//  din_3      in   WIDTH    operand source 2
//  out_valid  out  1        one-cycle pulse: result outputs updated
//  dout_low   out  WIDTH    result[WIDTH-1:0]
//  dout_high  out  WIDTH    result[2*WIDTH-1:WIDTH]
//  zero       out  1        result == 0
//  error      out  1        error for last command
// BEHAVIOUR
//  - Reset (rst==0 at posedge): state IDLE; dout_*, zero, error, out_valid, operand regs = 0; memory not cleared.
//  - Accept when cmd_valid && cmd_ready. Capture cmd_in, A, B and addr=din_1 in the same cycle.
//    sel 00/01/10 -> din_1/din_2/din_3; sel 11 -> A=dout_high, B=dout_low (values at accept).
//  - FSM: IDLE -(accept)-> EXEC. EXEC -> DONE (mode 00 or 11); -> WRITE (mode 01); -> READ (mode 10).
//    WRITE -> DONE. READ -> DONE. DONE -> IDLE. cmd_valid is ignored outside IDLE.
//  - EXEC: ALU result computed from registered A,B; zero-extended to 2*WIDTH.
//    000 ADD a+b; 001 SUB a-b, 2*WIDTH two's complement, error=1 if a<b; 010 MUL a*b;
//    011 AND; 100 OR; 101 XOR; 110 SHL a<<b[SH_W-1:0] truncated to 2*WIDTH; 111 PASS a.
//  - Mode 00 ALU only. Mode 01 ALU, then mem[addr]<=result in WRITE.
//    Mode 10 load: opcode/sel ignored; synchronous read issued in EXEC, data captured in READ.
//    Mode 11 reserved: result 0, error=1, no memory access.
//  - addr >= MEM_DEPTH on mode 01/10: write suppressed / load result 0; error=1.
//  - Result regs (dout_*, zero, error) update on the edge entering DONE and hold until the next DONE.
//    out_valid=1 only in DONE. zero = (result==0), independent of error.
//  - Latency accept->out_valid: 2 cycles (modes 00/11), 3 cycles (01/10).
//    Throughput: one command per 3 (resp. 4) cycles.
//  - Reset mid-operation aborts immediately. Reset asserted in the WRITE cycle suppresses the write.
//  - A command with sel 11 issued back-to-back uses the result of the previous DONE.
// CONFIGURATION
//  BK_PROC_SAT_EN defined: ADD saturates to {WIDTH{1'b1}} zero-extended if sum exceeds WIDTH bits.
//    SUB with a<b yields 0 (error=1, zero=1). Other ops unchanged.
//  BK_PROC_SAT_EN undefined: ADD yields full WIDTH+1-bit sum; SUB wraps as above.
// TESTING
//  1 Reset: rst=0 for 2 cycles mid-command -> all outputs 0, cmd_ready=1, out_valid=0.
//  2 ADD din_1=200 din_2=100, sel 00/01, mode 00, accepted at T -> out_valid at T+2,
//    dout_high=0x01 dout_low=0x2C; with SAT_EN 0x00FF; zero=0 error=0.
//  3 SUB 5-7 -> 0xFFFE, error=1, zero=0; with SAT_EN 0x0000, error=1, zero=1.
//  4 MUL 255*255 mode 01 addr 3 -> 0xFE01 at T+3. Then mode 10 addr 3 -> 0xFE01 at T+3.
//    Then mode 10 addr 20 -> 0x0000, error=1.
//  5 After 0xFE01, AND sel_a=11 sel_b=11 -> 0xFE&0x01 = 0x0000, zero=1.
//    SHL din_1=0x81 by din_2=4 -> 0x0810.
//  6 cmd_valid held high 8 cycles -> exactly 2 accepts (one per IDLE).
//    rst=0 during WRITE of store to addr 5 -> mem[5] unchanged on later load.

Source files
------------

// File: rtl/bk_stream_processor_if.sv
// Command/result bus of the bk stream processor: valid/ready command side plus
// the registered result outputs. The master drives commands, the slave is the engine.
interface bk_stream_processor_if #(
    parameter int WIDTH = 8
) ();
    logic             cmd_valid;
    logic             cmd_ready;
    logic [8:0]       cmd_in;
    logic [WIDTH-1:0] din_1;
    logic [WIDTH-1:0] din_2;
    logic [WIDTH-1:0] din_3;
    logic             out_valid;
    logic [WIDTH-1:0] dout_low;
    logic [WIDTH-1:0] dout_high;
    logic             zero;
    logic             error;

    modport master (
        output cmd_valid, cmd_in, din_1, din_2, din_3,
        input  cmd_ready, out_valid, dout_low, dout_high, zero, error
    );

    modport slave (
        input  cmd_valid, cmd_in, din_1, din_2, din_3,
        output cmd_ready, out_valid, dout_low, dout_high, zero, error
    );
endinterface

// File: rtl/bk_stream_processor.sv
// Command-driven ALU/memory engine: IDLE -> EXEC -> [WRITE|READ] -> DONE -> IDLE.
// Optional macro BK_PROC_SAT_EN: ADD saturates to all-ones, SUB underflow clamps to 0.
module bk_stream_processor #(
    parameter int WIDTH     = 8,
    parameter int MEM_DEPTH = 16
) (
    input logic clk,
    input logic rst,
    bk_stream_processor_if.slave bus
);
    localparam int ADDR_W = $clog2(MEM_DEPTH);
    localparam int SH_W   = $clog2(2 * WIDTH);
    localparam int RW     = 2 * WIDTH;

    typedef enum logic [2:0] {IDLE, EXEC, WRITE, READ, DONE} state_t;
    state_t state, nextState;

    logic [2:0]       op_p0;
    logic [1:0]       mode_p0;
    logic [WIDTH-1:0] opA_p0, opB_p0, addr_p0;
    logic [RW-1:0]    res_p1, rdData_p1;
    logic             err_p1;
    logic [RW-1:0]    doutReg;
    logic             zeroReg, errReg;
    logic [RW:0]      aluOut;
    logic [RW-1:0]    aluRes;
    logic             aluErr, accept, addrOk;
    logic [ADDR_W-1:0] addrIdx;
    logic [RW-1:0]    mem [MEM_DEPTH];

    function automatic logic [WIDTH-1:0] selOperand(input logic [1:0] sel,
        input logic [WIDTH-1:0] d1, d2, d3, fb);
        case (sel)
            2'b00:   return d1;
            2'b01:   return d2;
            2'b10:   return d3;
            default: return fb;
        endcase
    endfunction

    // Returns {error, result}; saturation behaviour lives here only.
    function automatic logic [RW:0] aluCompute(input logic [2:0] op,
        input logic [WIDTH-1:0] a, b);
        logic [RW-1:0]  res;
        logic           err;
        logic [WIDTH:0] sum;
        res = '0;
        err = 1'b0;
        sum = {1'b0, a} + {1'b0, b};
        case (op)
`ifdef BK_PROC_SAT_EN
            3'd0: res = sum[WIDTH] ? RW'({WIDTH{1'b1}}) : RW'(sum);
            3'd1: begin
                err = (a < b);
                res = err ? '0 : RW'(a) - RW'(b);
            end
`else
            3'd0: res = RW'(sum);
            3'd1: begin
                err = (a < b);
                res = RW'(a) - RW'(b);
            end
`endif
            3'd2:    res = RW'(a) * RW'(b);
            3'd3:    res = RW'(a & b);
            3'd4:    res = RW'(a | b);
            3'd5:    res = RW'(a ^ b);
            3'd6:    res = RW'(a) << b[SH_W-1:0];
            default: res = RW'(a);
        endcase
        return {err, res};
    endfunction

    assign accept  = bus.cmd_valid && (state == IDLE);
    assign addrOk  = int'(addr_p0) < MEM_DEPTH;
    assign addrIdx = addr_p0[ADDR_W-1:0];
    assign aluOut  = aluCompute(op_p0, opA_p0, opB_p0);
    assign aluRes  = aluOut[RW-1:0];
    assign aluErr  = aluOut[RW];

    always_ff @(posedge clk) begin
        if (!rst) state <= IDLE;
        else      state <= nextState;
    end

    always_comb begin
        nextState = state;
        case (state)
            IDLE: if (bus.cmd_valid) nextState = EXEC;
            EXEC: begin
                case (mode_p0)
                    2'b01:   nextState = WRITE;
                    2'b10:   nextState = READ;
                    default: nextState = DONE;
                endcase
            end
            WRITE:   nextState = DONE;
            READ:    nextState = DONE;
            default: nextState = IDLE;
        endcase
    end

    always_comb begin
        bus.cmd_ready = (state == IDLE);
        bus.out_valid = (state == DONE);
        bus.dout_low  = doutReg[WIDTH-1:0];
        bus.dout_high = doutReg[RW-1:WIDTH];
        bus.zero      = zeroReg;
        bus.error     = errReg;
    end

    // p0: command capture at accept; p1: ALU result held for the WRITE cycle
    always_ff @(posedge clk) begin
        if (!rst) begin
            op_p0   <= '0;
            mode_p0 <= '0;
            opA_p0  <= '0;
            opB_p0  <= '0;
            addr_p0 <= '0;
            res_p1  <= '0;
            err_p1  <= 1'b0;
            doutReg <= '0;
            zeroReg <= 1'b0;
            errReg  <= 1'b0;
        end else begin
            if (accept) begin
                op_p0   <= bus.cmd_in[8:6];
                mode_p0 <= bus.cmd_in[1:0];
                opA_p0  <= selOperand(bus.cmd_in[5:4], bus.din_1, bus.din_2, bus.din_3,
                                      doutReg[RW-1:WIDTH]);
                opB_p0  <= selOperand(bus.cmd_in[3:2], bus.din_1, bus.din_2, bus.din_3,
                                      doutReg[WIDTH-1:0]);
                addr_p0 <= bus.din_1;
            end
            if (state == EXEC) begin
                case (mode_p0)
                    2'b00: begin
                        doutReg <= aluRes;
                        zeroReg <= (aluRes == '0);
                        errReg  <= aluErr;
                    end
                    2'b01: begin
                        res_p1 <= aluRes;
                        err_p1 <= aluErr || !addrOk;
                    end
                    2'b11: begin
                        doutReg <= '0;
                        zeroReg <= 1'b1;
                        errReg  <= 1'b1;
                    end
                    default: ;
                endcase
            end
            if (state == WRITE) begin
                doutReg <= res_p1;
                zeroReg <= (res_p1 == '0);
                errReg  <= err_p1;
            end
            if (state == READ) begin
                doutReg <= addrOk ? rdData_p1 : '0;
                zeroReg <= !addrOk || (rdData_p1 == '0);
                errReg  <= !addrOk;
            end
        end
    end

    // Memory is never cleared; a reset during WRITE blocks the store.
    always_ff @(posedge clk) begin
        if (rst && state == WRITE && addrOk) mem[addrIdx] <= res_p1;
        if (state == EXEC) rdData_p1 <= mem[addrIdx];
    end
endmodule

// File: tb/tb_bk_stream_processor.sv
// Directed self-checking bench for bk_stream_processor (honours BK_PROC_SAT_EN).
module tb_bk_stream_processor;
    logic clk = 1'b0;
    logic rst = 1'b0;
    int   checks = 0;
    int   failures = 0;

    bk_stream_processor_if #(.WIDTH(8)) bus ();

    bk_stream_processor #(.WIDTH(8), .MEM_DEPTH(16)) dut (
        .clk(clk), .rst(rst), .bus(bus.slave)
    );

    always #5 clk = ~clk;

    task automatic issue(input logic [2:0] op, input logic [1:0] sa, sb, md,
                         input logic [7:0] d1, d2, d3);
        bit ok;
        ok = 0;
        @(negedge clk);
        for (int i = 0; i < 20; i++) begin
            if (bus.cmd_ready) begin ok = 1; break; end
            @(negedge clk);
        end
        if (ok) begin
            bus.cmd_in = {op, sa, sb, md};
            bus.din_1 = d1; bus.din_2 = d2; bus.din_3 = d3;
            bus.cmd_valid = 1'b1;
            @(posedge clk);
            #1 bus.cmd_valid = 1'b0;
        end
    endtask

    task automatic waitResult(output int lat, output logic [15:0] res, output logic z, e);
        lat = -1;
        for (int i = 1; i <= 20; i++) begin
            @(negedge clk);
            if (bus.out_valid) begin lat = i; break; end
        end
        res = {bus.dout_high, bus.dout_low};
        z = bus.zero;
        e = bus.error;
    endtask

    task automatic runCmd(input logic [2:0] op, input logic [1:0] sa, sb, md,
                          input logic [7:0] d1, d2, d3,
                          output int lat, output logic [15:0] res, output logic z, e);
        issue(op, sa, sb, md, d1, d2, d3);
        waitResult(lat, res, z, e);
    endtask

    task automatic test_reset;
        int lat; logic [15:0] res; logic z, e;
        bus.cmd_valid = 1'b0; bus.cmd_in = '0;
        bus.din_1 = '0; bus.din_2 = '0; bus.din_3 = '0;
        rst = 1'b0;
        repeat (3) @(posedge clk);
        @(negedge clk);
        checks++;
        if ({bus.dout_high, bus.dout_low, bus.zero, bus.error, bus.out_valid, bus.cmd_ready} !== 19'h1) begin
            failures++;
            $display("FAIL reset_init got %h want 00001", {bus.dout_high, bus.dout_low, bus.zero, bus.error, bus.out_valid, bus.cmd_ready});
        end
        rst = 1'b1;
        // Make the result registers non-zero, then abort a command mid-flight.
        runCmd(3'd7, 2'b00, 2'b00, 2'b00, 8'hA5, 8'h00, 8'h00, lat, res, z, e);
        checks++;
        if (res !== 16'h00A5) begin failures++; $display("FAIL pass_res got %h want 00a5", res); end
        issue(3'd0, 2'b00, 2'b01, 2'b01, 8'd1, 8'd2, 8'd0);
        rst = 1'b0;
        repeat (2) @(posedge clk);
        @(negedge clk);
        checks++;
        if ({bus.dout_high, bus.dout_low, bus.zero, bus.error} !== 18'h0) begin
            failures++; $display("FAIL reset_mid_out got %h want 0", {bus.dout_high, bus.dout_low, bus.zero, bus.error});
        end
        checks++;
        if ({bus.cmd_ready, bus.out_valid} !== 2'b10) begin
            failures++; $display("FAIL reset_mid_hs got %b want 10", {bus.cmd_ready, bus.out_valid});
        end
        rst = 1'b1;
    endtask

    task automatic test_add;
        int lat; logic [15:0] res; logic z, e; logic [15:0] want;
`ifdef BK_PROC_SAT_EN
        want = 16'h00FF;
`else
        want = 16'h012C;
`endif
        runCmd(3'd0, 2'b00, 2'b01, 2'b00, 8'd200, 8'd100, 8'd0, lat, res, z, e);
        checks++;
        if (lat !== 2) begin failures++; $display("FAIL add_lat got %0d want 2", lat); end
        checks++;
        if ({res, z, e} !== {want, 2'b00}) begin
            failures++; $display("FAIL add_res got %h z%b e%b want %h z0 e0", res, z, e, want);
        end
    endtask

    task automatic test_sub;
        int lat; logic [15:0] res; logic z, e; logic [15:0] want; logic wz;
`ifdef BK_PROC_SAT_EN
        want = 16'h0000; wz = 1'b1;
`else
        want = 16'hFFFE; wz = 1'b0;
`endif
        runCmd(3'd1, 2'b00, 2'b01, 2'b00, 8'd5, 8'd7, 8'd0, lat, res, z, e);
        checks++;
        if ({res, z, e} !== {want, wz, 1'b1}) begin
            failures++; $display("FAIL sub_res got %h z%b e%b want %h z%b e1", res, z, e, want, wz);
        end
    endtask

    task automatic test_memory;
        int lat; logic [15:0] res; logic z, e;
        runCmd(3'd2, 2'b01, 2'b10, 2'b01, 8'd3, 8'd255, 8'd255, lat, res, z, e);
        checks++;
        if (lat !== 3) begin failures++; $display("FAIL store_lat got %0d want 3", lat); end
        checks++;
        if ({res, z, e} !== {16'hFE01, 2'b00}) begin
            failures++; $display("FAIL store_res got %h z%b e%b want fe01 z0 e0", res, z, e);
        end
        runCmd(3'd0, 2'b00, 2'b00, 2'b10, 8'd3, 8'd0, 8'd0, lat, res, z, e);
        checks++;
        if (lat !== 3) begin failures++; $display("FAIL load_lat got %0d want 3", lat); end
        checks++;
        if ({res, z, e} !== {16'hFE01, 2'b00}) begin
            failures++; $display("FAIL load_res got %h z%b e%b want fe01 z0 e0", res, z, e);
        end
    endtask

    task automatic test_feedback;
        int lat; logic [15:0] res; logic z, e;
        runCmd(3'd3, 2'b11, 2'b11, 2'b00, 8'hFF, 8'hFF, 8'hFF, lat, res, z, e);
        checks++;
        if ({res, z, e} !== {16'h0000, 2'b10}) begin
            failures++; $display("FAIL and_fb got %h z%b e%b want 0000 z1 e0", res, z, e);
        end
        runCmd(3'd6, 2'b00, 2'b01, 2'b00, 8'h81, 8'd4, 8'd0, lat, res, z, e);
        checks++;
        if ({res, z, e} !== {16'h0810, 2'b00}) begin
            failures++; $display("FAIL shl got %h z%b e%b want 0810 z0 e0", res, z, e);
        end
        runCmd(3'd5, 2'b10, 2'b01, 2'b00, 8'h00, 8'h3C, 8'h0F, lat, res, z, e);
        checks++;
        if (res !== 16'h0033) begin failures++; $display("FAIL xor got %h want 0033", res); end
    endtask

    task automatic test_errors;
        int lat; logic [15:0] res; logic z, e;
        runCmd(3'd0, 2'b00, 2'b00, 2'b10, 8'd20, 8'd0, 8'd0, lat, res, z, e);
        checks++;
        if ({res, z, e} !== {16'h0000, 2'b11}) begin
            failures++; $display("FAIL load_oob got %h z%b e%b want 0000 z1 e1", res, z, e);
        end
        runCmd(3'd0, 2'b01, 2'b10, 2'b11, 8'd1, 8'd9, 8'd9, lat, res, z, e);
        checks++;
        if ({lat, res, z, e} !== {32'd2, 16'h0000, 2'b11}) begin
            failures++; $display("FAIL mode11 got lat%0d %h z%b e%b want lat2 0000 z1 e1", lat, res, z, e);
        end
        runCmd(3'd0, 2'b01, 2'b10, 2'b01, 8'd20, 8'd1, 8'd1, lat, res, z, e);
        checks++;
        if ({res, z, e} !== {16'h0002, 2'b01}) begin
            failures++; $display("FAIL store_oob got %h z%b e%b want 0002 z0 e1", res, z, e);
        end
    endtask

    task automatic test_back_to_back;
        int accepts;
        bit ready;
        accepts = 0;
        ready = 0;
        @(negedge clk);
        for (int i = 0; i < 20; i++) begin
            if (bus.cmd_ready) begin ready = 1; break; end
            @(negedge clk);
        end
        bus.cmd_in = {3'd0, 2'b01, 2'b10, 2'b01};
        bus.din_1 = 8'd7; bus.din_2 = 8'd3; bus.din_3 = 8'd4;
        bus.cmd_valid = ready;
        for (int i = 0; i < 8; i++) begin
            if (i > 0) @(negedge clk);
            if (bus.cmd_valid && bus.cmd_ready) accepts++;
        end
        bus.cmd_valid = 1'b0;
        checks++;
        if (accepts !== 2) begin failures++; $display("FAIL b2b_accepts got %0d want 2", accepts); end
        checks++;
        if ({bus.out_valid, bus.dout_high, bus.dout_low} !== 17'h10007) begin
            failures++; $display("FAIL b2b_res got %h want 10007", {bus.out_valid, bus.dout_high, bus.dout_low});
        end
    endtask

    task automatic test_reset_write;
        int lat; logic [15:0] res; logic z, e;
        runCmd(3'd0, 2'b01, 2'b10, 2'b01, 8'd5, 8'h10, 8'h01, lat, res, z, e);
        issue(3'd0, 2'b01, 2'b10, 2'b01, 8'd5, 8'h20, 8'h02);
        @(posedge clk);
        #1 rst = 1'b0;
        @(posedge clk);
        #1 rst = 1'b1;
        runCmd(3'd0, 2'b00, 2'b00, 2'b10, 8'd5, 8'd0, 8'd0, lat, res, z, e);
        checks++;
        if ({res, e} !== {16'h0011, 1'b0}) begin
            failures++; $display("FAIL reset_write got %h e%b want 0011 e0", res, e);
        end
    endtask

    initial begin
        test_reset();
        test_add();
        test_sub();
        test_memory();
        test_feedback();
        test_errors();
        test_back_to_back();
        test_reset_write();
        $display("End of test - %0d assertions evaluated, %0d failures", checks, failures);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog simulation time limit reached");
        $fatal(1);
    end
endmodule
